// File: rtl/demux_destino_pkg.sv
// Shared constants for the demux_destino egress receiver: FIFO indexing and word layout.
package demux_destino_pkg;

  localparam int NUM_FIFOS   = 4;
  localparam int D0VC0       = 0;
  localparam int D0VC1       = 1;
  localparam int D1VC0       = 2;
  localparam int D1VC1       = 3;

  localparam int VC_BIT      = 4;
  localparam int PAYLOAD_MSB = 3;

  typedef logic [PAYLOAD_MSB:0] payload_t;

  // Destination FIFO index is {dest, vc}.
  function automatic logic [1:0] fifo_index(input logic dest, input logic vc);
    return {dest, vc};
  endfunction

endpackage

// File: rtl/demux_destino_fifo_dest.sv
// Single-clock destination FIFO with registered read port and occupancy flags.
module fifo_dest import demux_destino_pkg::*; #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic     clk,
  input  logic     reset_L,
  input  logic     push,
  input  payload_t push_data,
  input  logic     pop,
  output payload_t data,
  output logic     valid,
  output logic     empty,
  output logic     almost_empty,
  output logic     almost_full,
  output logic     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  payload_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // A pop needs stored data, so push+pop on an empty FIFO writes without fall-through.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= pop_ok;
      if (pop_ok) begin
        data   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/demux_destino.sv
// Egress receiver: steers two destination streams into four {dest,vc} FIFOs with upstream pause.
// Optional DEMUX_DROP_CNT_EN adds dropCnt, an 8-bit saturating count of dropped words.
module demux_destino import demux_destino_pkg::*; #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [4:0] dataIn_0,
  input  logic [4:0] dataIn_1,
  input  logic [1:0] validIn,
  input  logic [3:0] pop,
  output logic [3:0] dataOut_0VC0,
  output logic [3:0] dataOut_0VC1,
  output logic [3:0] dataOut_1VC0,
  output logic [3:0] dataOut_1VC1,
  output logic [3:0] validOut,
  output logic [3:0] empty,
  output logic [3:0] almostEmpty,
  output logic [3:0] almostFull,
  output logic       pause,
  output logic       overflowErr
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0] dropCnt
`endif
);

  logic [NUM_FIFOS-1:0] push;
  payload_t             push_data [NUM_FIFOS];
  payload_t             fifo_data [NUM_FIFOS];
  logic [NUM_FIFOS-1:0] drop;

  always_comb begin
    push             = '0;
    push_data[D0VC0] = dataIn_0[PAYLOAD_MSB:0];
    push_data[D0VC1] = dataIn_0[PAYLOAD_MSB:0];
    push_data[D1VC0] = dataIn_1[PAYLOAD_MSB:0];
    push_data[D1VC1] = dataIn_1[PAYLOAD_MSB:0];
    if (validIn[0]) begin
      push[fifo_index(1'b0, dataIn_0[VC_BIT])] = 1'b1;
    end
    if (validIn[1]) begin
      push[fifo_index(1'b1, dataIn_1[VC_BIT])] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
    fifo_dest #(
      .DEPTH    (DEPTH),
      .AF_THRESH(AF_THRESH),
      .AE_THRESH(AE_THRESH)
    ) u_fifo (
      .clk         (clk),
      .reset_L     (reset_L),
      .push        (push[i]),
      .push_data   (push_data[i]),
      .pop         (pop[i]),
      .data        (fifo_data[i]),
      .valid       (validOut[i]),
      .empty       (empty[i]),
      .almost_empty(almostEmpty[i]),
      .almost_full (almostFull[i]),
      .drop        (drop[i])
    );
  end

  assign dataOut_0VC0 = fifo_data[D0VC0];
  assign dataOut_0VC1 = fifo_data[D0VC1];
  assign dataOut_1VC0 = fifo_data[D1VC0];
  assign dataOut_1VC1 = fifo_data[D1VC1];

  // Pause follows the flags by one cycle; headroom above AF_THRESH covers words in flight.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pause       <= 1'b0;
      overflowErr <= 1'b0;
    end else begin
      pause <= |almostFull;
      if (|drop) begin
        overflowErr <= 1'b1;
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [1:0] drop_num;
  logic [8:0] drop_sum;

  // Each stream targets one FIFO of its own destination, so at most two drops per cycle.
  assign drop_num = {1'b0, drop[D0VC0] | drop[D0VC1]} + {1'b0, drop[D1VC0] | drop[D1VC1]};
  assign drop_sum = {1'b0, dropCnt} + {7'b0, drop_num};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      dropCnt <= 8'h00;
    end else begin
      dropCnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif

endmodule
